// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - execute-stage ALU with bit-serial shifts and valid/ready handshake
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUcontrol_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_shifted, alu_res;
  logic [SW-1:0]    cnt, shamt;
  logic [3:0]       op;
  logic             accept, is_shift, slt_bit;

  assign shamt    = b[SW-1:0];
  assign accept   = in_valid & in_ready;
  assign is_shift = (ALUcontrol_in == OP_SLL) || (ALUcontrol_in == OP_SRL) ||
                    (ALUcontrol_in == OP_SRA);
  assign slt_bit  = ($signed(a) < $signed(b));

  always_comb begin
    alu_res = '0;
    case (ALUcontrol_in)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the in-flight shift; op is only meaningful while in SHIFT
  always_comb begin
    acc_shifted = acc;
    case (op)
      OP_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
      default: acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      cnt    <= '0;
      op     <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift) begin
              acc <= a;
              cnt <= shamt;
              op  <= ALUcontrol_in;
              if (shamt == '0) begin
                result <= a;
                zero   <= (a == '0);
              end
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
            end
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result <= acc_shifted;
            zero   <= (acc_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed scoreboard bench for alu_iterative
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUcontrol_in;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];

  alu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcontrol_in(ALUcontrol_in), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] code, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (code)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: return x << sh;
      4'b1001: return x >> sh;
      4'b1010: return 32'($signed(x) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one op, measure accept-to-out_valid latency, score it, then drain
  // (holding out_ready low for 'hold' cycles while poking ignored inputs).
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] av,
                        input logic [31:0] bv, input int hold);
    int          t, lat, exp_lat;
    logic        rdy_seen;
    logic [32:0] e;
    logic [31:0] held;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    exp_lat = (code == 4'b1000 || code == 4'b1001 || code == 4'b1010) ? 1 + int'(bv[4:0]) : 1;
    exp_q.push_back({(model(code, av, bv) == 32'd0), model(code, av, bv)});
    out_ready     = (hold == 0);
    in_valid      = 1'b1;
    ALUcontrol_in = code;
    a             = av;
    b             = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ALUcontrol_in = 4'($urandom);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_ready"}, {31'd0, rdy_seen | in_ready}, 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_dead_beef;
    check({tag, "_result"}, result, e[31:0]);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, e[32]});
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; ALUcontrol_in = 4'b0010;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_bp_result"}, result, held);
      check({tag, "_bp_state"}, {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
    check({tag, "_kept"}, result, e[31:0]);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUcontrol_in = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, out_valid, in_ready}, 32'b001);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_eq",  4'b0110, 32'h0000_1234, 32'h0000_1234, 0);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_pos", 4'b0111, 32'd5, 32'hFFFF_FFFE, 0);
    run_op("and",     4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op("or",      4'b0001, 32'hF000_0001, 32'h0000_0F10, 0);
    run_op("sra31",   4'b1010, 32'h8000_0000, 32'd31, 0);
    run_op("sll0",    4'b1000, 32'h0000_0001, 32'h0000_0020, 0);
    run_op("srl4",    4'b1001, 32'h0000_00F0, 32'd4, 0);
    run_op("sll7",    4'b1000, 32'h8123_4567, 32'd7, 0);
    run_op("badop",   4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("bp_add",  4'b0010, 32'h0000_1000, 32'h0000_0234, 5);

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", result, 32'h0000_1234);
    check("idle_flags", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset in the middle of a long shift discards it asynchronously
    in_valid = 1'b1; ALUcontrol_in = 4'b1000; a = 32'h0000_0003; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("mid_busy", {30'd0, out_valid, in_ready}, 32'b00);
    reset_n = 1'b0;
    #1;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_flags", {29'd0, zero, out_valid, in_ready}, 32'b001);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
